// File: rtl/dm_ctrl_pkg.sv
// Shared encodings and helpers for the dm_ctrl data memory controller:
// access sizes, controller states, byte-lane enables and alignment checks.
package dm_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  // Lanes touched by an access of the given size at byte offset off; size 3 touches none.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = 4'b0011 << off;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic align_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = off[0];
      SZ_WORD: align_err = (off != 2'b00);
      default: align_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// CPU and debug port bundle of dm_ctrl; master is the core/bench side,
// slave is the memory controller.
interface dm_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024
);
  localparam int DBG_AW = $clog2(DEPTH);

  logic              DM_enable;
  logic              DM_read;
  logic              DM_write;
  logic [1:0]        DM_size;
  logic [ADDR_W-1:0] DM_address;
  logic [31:0]       DMin;
  logic [31:0]       DMout;
  logic              DM_valid;
  logic              DM_err;
  logic              DM_ready;

  logic              DBG_enable;
  logic              DBG_write;
  logic [DBG_AW-1:0] DBG_address;
  logic [31:0]       DBG_in;
  logic [31:0]       DBG_out;
  logic              DBG_collision;

  modport master (
    output DM_enable, DM_read, DM_write, DM_size, DM_address, DMin,
    output DBG_enable, DBG_write, DBG_address, DBG_in,
    input  DMout, DM_valid, DM_err, DM_ready, DBG_out, DBG_collision
  );

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_size, DM_address, DMin,
    input  DBG_enable, DBG_write, DBG_address, DBG_in,
    output DMout, DM_valid, DM_err, DM_ready, DBG_out, DBG_collision
  );

endinterface

// File: rtl/dm_ctrl_array.sv
// Dual-port read-first word array: port A has per-lane write enables,
// port B writes whole words. Reads are combinational, writes land on the edge.
module dm_ctrl_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic [AW-1:0]       addrA_i,
  input  logic [DATA_W/8-1:0] weA_i,
  input  logic [DATA_W-1:0]   wdataA_i,
  output logic [DATA_W-1:0]   rdataA_o,
  input  logic [AW-1:0]       addrB_i,
  input  logic                weB_i,
  input  logic [DATA_W-1:0]   wdataB_i,
  output logic [DATA_W-1:0]   rdataB_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdataA_o = mem_q[addrA_i];
  assign rdataB_o = mem_q[addrB_i];

  // The controller never lets both ports write the same cycle while port A is writing.
  always_ff @(posedge clock) begin
    for (int lane = 0; lane < DATA_W / 8; lane++) begin
      if (weA_i[lane]) mem_q[addrA_i][8*lane +: 8] <= wdataA_i[8*lane +: 8];
    end
    if (weB_i) mem_q[addrB_i] <= wdataB_i;
  end

endmodule

// File: rtl/dm_ctrl.sv
// Byte-addressed data memory controller: post-reset clear, size/alignment and
// range checking, 1- or 2-cycle CPU read pipeline, and a debug word port.
module dm_ctrl #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 12,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic      clock,
  input logic      reset,
  dm_ctrl_if.slave bus
);
  import dm_ctrl_pkg::*;

  localparam int AW        = $clog2(DEPTH);
  localparam int IDX_W     = ADDR_W - 2;
  localparam int IDX_LIM_W = IDX_W + 1;
  localparam logic [IDX_LIM_W-1:0] DEPTH_LIM = IDX_LIM_W'(DEPTH);
  localparam logic [AW-1:0]        LAST_IDX  = AW'(DEPTH - 1);

  state_e            state_q;
  logic [AW-1:0]     clearCnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] dmOut_q, stgData_q, dbgOut_q;
  logic              dmValid_q, dmErr_q, stgValid_q, stgErr_q, dbgColl_q;

  logic [IDX_W-1:0]  wordIdx;
  logic [1:0]        laneOff;
  logic              outOfRange, accessErr, clearing;
  logic              cpuWr, cpuRd, dbgWr, dbgRd, dbgColl_d;
  logic [3:0]        laneWe;
  logic [DATA_W-1:0] wrData, rdWordA, rdWordB, rdShift, loadData_d, portBData;
  logic [AW-1:0]     portBAddr;
  logic              portBWe;

  assign wordIdx    = bus.DM_address[ADDR_W-1:2];
  assign laneOff    = bus.DM_address[1:0];
  assign outOfRange = {1'b0, wordIdx} >= DEPTH_LIM;
  assign accessErr  = outOfRange | align_err(bus.DM_size, laneOff);
  assign clearing   = (state_q == ST_CLEAR);

  // Write wins over read; a debug write loses to any CPU write, even a faulting one.
  assign cpuWr     = ready_q & bus.DM_enable & bus.DM_write;
  assign cpuRd     = ready_q & bus.DM_enable & bus.DM_read & ~bus.DM_write;
  assign dbgWr     = ready_q & bus.DBG_enable & bus.DBG_write & ~cpuWr;
  assign dbgColl_d = ready_q & bus.DBG_enable & bus.DBG_write & cpuWr;
  assign dbgRd     = ready_q & bus.DBG_enable & ~bus.DBG_write;

  assign laneWe    = (cpuWr & ~accessErr) ? lane_mask(bus.DM_size, laneOff) : 4'b0000;
  assign wrData    = bus.DMin << {laneOff, 3'b000};
  assign portBWe   = clearing | dbgWr;
  assign portBAddr = clearing ? clearCnt_q : bus.DBG_address;
  assign portBData = clearing ? '0 : bus.DBG_in;
  assign rdShift   = rdWordA >> {laneOff, 3'b000};

  always_comb begin
    loadData_d = '0;
    if (!accessErr) begin
      case (bus.DM_size)
        SZ_BYTE: loadData_d = DATA_W'(rdShift[7:0]);
        SZ_HALF: loadData_d = DATA_W'(rdShift[15:0]);
        default: loadData_d = rdShift;
      endcase
    end
  end

  dm_ctrl_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .addrA_i (wordIdx[AW-1:0]),
    .weA_i   (laneWe),
    .wdataA_i(wrData),
    .rdataA_o(rdWordA),
    .addrB_i (portBAddr),
    .weB_i   (portBWe),
    .wdataB_i(portBData),
    .rdataB_o(rdWordB)
  );

  // Write errors always report one cycle after the request; read results follow RD_LAT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clearCnt_q <= '0;
      ready_q    <= 1'b0;
      stgValid_q <= 1'b0;
      stgErr_q   <= 1'b0;
      stgData_q  <= '0;
      dmValid_q  <= 1'b0;
      dmErr_q    <= 1'b0;
      dmOut_q    <= '0;
      dbgOut_q   <= '0;
      dbgColl_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clearCnt_q <= clearCnt_q + AW'(1);
          if (clearCnt_q == LAST_IDX) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase

      stgValid_q <= cpuRd;
      stgErr_q   <= cpuRd & accessErr;
      stgData_q  <= cpuRd ? loadData_d : '0;

      if (RD_LAT == 2) begin
        dmValid_q <= stgValid_q;
        dmOut_q   <= stgData_q;
        dmErr_q   <= stgErr_q | (cpuWr & accessErr);
      end else begin
        dmValid_q <= cpuRd;
        dmOut_q   <= cpuRd ? loadData_d : '0;
        dmErr_q   <= (cpuRd | cpuWr) & accessErr;
      end

      dbgColl_q <= dbgColl_d;
      if (dbgRd) dbgOut_q <= rdWordB;
    end
  end

  assign bus.DMout         = dmOut_q;
  assign bus.DM_valid      = dmValid_q;
  assign bus.DM_err        = dmErr_q;
  assign bus.DM_ready      = ready_q;
  assign bus.DBG_out       = dbgOut_q;
  assign bus.DBG_collision = dbgColl_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: RD_LAT=1 and RD_LAT=2 instances driven in lockstep and
// compared every cycle against a word/byte-level memory model.
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 12;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dm_ctrl_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus1 ();
  dm_ctrl_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus2 ();

  dm_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1), .CLEAR_ON_RESET(1))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));
  dm_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2), .CLEAR_ON_RESET(1))
    dut2 (.clock(clock), .reset(reset), .bus(bus2));

  int checks = 0;
  int errors = 0;

  logic [31:0]       mem [DEPTH];
  int                clearLeft;
  logic [31:0]       expData1, expData2, expDbg, pendData;
  logic              expValid1, expErr1, expValid2, expErr2, pendValid, pendErr;
  logic              expColl, expReady;

  logic              stEn, stRd, stWr, stDEn, stDWr;
  logic [1:0]        stSize;
  logic [ADDR_W-1:0] stAddr;
  logic [3:0]        stDAddr;
  logic [31:0]       stDin, stDIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("dut1_DMout",     bus1.DMout, expData1);
    check("dut1_DM_valid",  32'(bus1.DM_valid), 32'(expValid1));
    check("dut1_DM_err",    32'(bus1.DM_err), 32'(expErr1));
    check("dut1_DM_ready",  32'(bus1.DM_ready), 32'(expReady));
    check("dut1_DBG_out",   bus1.DBG_out, expDbg);
    check("dut1_DBG_coll",  32'(bus1.DBG_collision), 32'(expColl));
    check("dut2_DMout",     bus2.DMout, expData2);
    check("dut2_DM_valid",  32'(bus2.DM_valid), 32'(expValid2));
    check("dut2_DM_err",    32'(bus2.DM_err), 32'(expErr2));
    check("dut2_DM_ready",  32'(bus2.DM_ready), 32'(expReady));
    check("dut2_DBG_out",   bus2.DBG_out, expDbg);
    check("dut2_DBG_coll",  32'(bus2.DBG_collision), 32'(expColl));
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    clearLeft = DEPTH;
    expData1 = '0; expData2 = '0; expDbg = '0; pendData = '0;
    expValid1 = 1'b0; expErr1 = 1'b0; expValid2 = 1'b0; expErr2 = 1'b0;
    pendValid = 1'b0; pendErr = 1'b0; expColl = 1'b0; expReady = 1'b0;
  endtask

  // One clock edge of the memory as seen from outside: reads see the old contents.
  task automatic modelEdge();
    logic [31:0] rdD;
    logic [63:0] wide;
    logic        rdV, rdE, wrE, coll, bad;
    int          idx, off, nb;
    rdD = '0; rdV = 1'b0; rdE = 1'b0; wrE = 1'b0; coll = 1'b0;
    expData2  = pendData;
    expValid2 = pendValid;
    if (clearLeft > 0) begin
      clearLeft--;
    end else begin
      idx = int'(stAddr) / 4;
      off = int'(stAddr) % 4;
      nb  = (stSize == 2'd0) ? 1 : (stSize == 2'd1) ? 2 : (stSize == 2'd2) ? 4 : 0;
      bad = (nb == 0) ? 1'b1 : (((off % nb) != 0) || (idx >= DEPTH));
      if (stEn && !stWr && stRd) begin
        rdV = 1'b1;
        if (bad) rdE = 1'b1;
        else begin
          wide = {32'b0, mem[idx]} >> (8 * off);
          rdD  = wide[31:0] & ((nb == 4) ? 32'hFFFF_FFFF : (nb == 2) ? 32'h0000_FFFF : 32'h0000_00FF);
        end
      end
      if (stDEn && !stDWr) expDbg = mem[stDAddr];
      if (stEn && stWr) begin
        if (bad) wrE = 1'b1;
        else for (int b = 0; b < nb; b++) mem[idx][8*(off+b) +: 8] = stDin[8*b +: 8];
      end
      if (stDEn && stDWr) begin
        if (stEn && stWr) coll = 1'b1;
        else mem[stDAddr] = stDIn;
      end
    end
    expData1 = rdD; expValid1 = rdV; expErr1 = rdE | wrE;
    expErr2  = pendErr | wrE;
    expColl  = coll;
    expReady = (clearLeft == 0);
    pendData = rdD; pendValid = rdV; pendErr = rdE;
  endtask

  task automatic setBus(input int e, input int r, input int w, input int s, input int a,
                        input logic [31:0] d, input int de, input int dw, input int da,
                        input logic [31:0] di);
    stEn = (e != 0); stRd = (r != 0); stWr = (w != 0); stSize = 2'(s);
    stAddr = ADDR_W'(a); stDin = d; stDEn = (de != 0); stDWr = (dw != 0);
    stDAddr = 4'(da); stDIn = di;
    bus1.DM_enable = stEn;    bus2.DM_enable = stEn;
    bus1.DM_read = stRd;      bus2.DM_read = stRd;
    bus1.DM_write = stWr;     bus2.DM_write = stWr;
    bus1.DM_size = stSize;    bus2.DM_size = stSize;
    bus1.DM_address = stAddr; bus2.DM_address = stAddr;
    bus1.DMin = stDin;        bus2.DMin = stDin;
    bus1.DBG_enable = stDEn;  bus2.DBG_enable = stDEn;
    bus1.DBG_write = stDWr;   bus2.DBG_write = stDWr;
    bus1.DBG_address = stDAddr; bus2.DBG_address = stDAddr;
    bus1.DBG_in = stDIn;      bus2.DBG_in = stDIn;
  endtask

  task automatic applyStimulus(input int e, input int r, input int w, input int s, input int a,
                               input logic [31:0] d, input int de, input int dw, input int da,
                               input logic [31:0] di);
    setBus(e, r, w, s, a, d, de, dw, da, di);
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
  endtask
  task automatic cpuWrite(input int s, input int a, input logic [31:0] d);
    applyStimulus(1, 0, 1, s, a, d, 0, 0, 0, '0);
  endtask
  task automatic cpuRead(input int s, input int a);
    applyStimulus(1, 1, 0, s, a, '0, 0, 0, 0, '0);
  endtask
  task automatic dbgWrite(input int da, input logic [31:0] di);
    applyStimulus(0, 0, 0, 0, 0, '0, 1, 1, da, di);
  endtask
  task automatic dbgRead(input int da);
    applyStimulus(0, 0, 0, 0, 0, '0, 1, 0, da, '0);
  endtask

  // Asserts reset between edges and expects every output to drop at once.
  task automatic doReset();
    setBus(0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitClear();
    for (int i = 1; i <= DEPTH; i++) begin
      idle();
      if (i == DEPTH - 1) check("ready_before_depth", 32'(bus1.DM_ready), 32'd0);
    end
    check("ready_at_depth", 32'(bus1.DM_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    setBus(0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
    modelReset();
    repeat (2) @(negedge clock);
    checkOutput();
    reset = 1'b0;

    $display("[TB] clear after reset");
    waitClear();
    for (int w = 0; w < DEPTH; w++) dbgRead(w);

    $display("[TB] byte store and half load");
    dbgWrite(3, 32'h1122_3344);
    cpuWrite(SZ_BYTE, 13, 32'h0000_00AB);
    dbgRead(3);
    check("dbg_word3_after_byte", bus1.DBG_out, 32'h1122_AB44);
    cpuRead(SZ_HALF, 14);
    check("half_load_lat1", bus1.DMout, 32'h0000_1122);
    idle();
    check("half_load_lat2", bus2.DMout, 32'h0000_1122);

    $display("[TB] misaligned and out-of-range");
    dbgWrite(1, 32'hCAFE_F00D);
    cpuWrite(SZ_WORD, 6, 32'h1234_5678);
    check("misaligned_store_err_lat1", 32'(bus1.DM_err), 32'd1);
    check("misaligned_store_err_lat2", 32'(bus2.DM_err), 32'd1);
    dbgRead(1);
    check("word1_unchanged", bus1.DBG_out, 32'hCAFE_F00D);
    cpuRead(SZ_WORD, 4 * DEPTH);
    check("oor_read_valid", 32'(bus1.DM_valid), 32'd1);
    check("oor_read_err", 32'(bus1.DM_err), 32'd1);
    cpuRead(3, 0);
    cpuRead(SZ_HALF, 5);
    idle();

    $display("[TB] debug write collision");
    applyStimulus(1, 0, 1, SZ_WORD, 8, 32'hDEAD_BEEF, 1, 1, 2, 32'h0000_0005);
    check("collision_pulse", 32'(bus1.DBG_collision), 32'd1);
    dbgRead(2);
    check("collision_word2", bus1.DBG_out, 32'hDEAD_BEEF);
    check("collision_single", 32'(bus1.DBG_collision), 32'd0);

    $display("[TB] back-to-back reads");
    for (int w = 0; w < 4; w++) dbgWrite(w, 32'(w + 1));
    for (int i = 0; i < 4; i++) begin
      cpuRead(SZ_WORD, 4 * i);
      if (i > 0) check("b2b_lat2_data", bus2.DMout, 32'(i));
    end
    idle();
    check("b2b_lat2_last", bus2.DMout, 32'd4);

    $display("[TB] reset mid-read and mid-clear");
    cpuRead(SZ_WORD, 4);
    doReset();
    repeat (6) idle();
    doReset();
    waitClear();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(int'($urandom_range(0, 9) < 8), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4 * DEPTH + 15)), $urandom(),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, DEPTH - 1)), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
